// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store func3 encodings and the latched request control fields.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Address and data are parameter-sized, so they are latched beside this struct.
  typedef struct packed {
    logic       write;
    logic [2:0] func3;
  } lsu_req_t;

  function automatic logic func3_legal(input logic write, input logic [2:0] func3);
    if (write) return func3 inside {SB, SH, SW};
    else       return func3 inside {LB, LH, LW, LBU, LHU};
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational misalignment detector for halfword/word accesses.
// Instantiated by load_store_unit only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] func3_i,
  input  logic [1:0] addr_i,
  output logic       misaligned_o
);

  // Store func3 values alias the load ones (SH==LH, SW==LW), so one decode serves both.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    misaligned_o = 1'b0;
    case (func3_i)
      LH, LHU: misaligned_o = addr_i[0];
      LW:      misaligned_o = (addr_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request from execute, issues a single command
// to the data memory controller, waits for completion and returns a response.
// Optional alignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_func3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_read_En,
  output logic                     mem_write_En,
  output logic [2:0]               mem_func3,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_e                   state_q;
  lsu_req_t                 req_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     misaligned;
  logic                     reject;
  logic [CNT_W-1:0]         cnt_d;
  logic                     timeout;

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_align_check u_align_check (
    .func3_i      (req_func3),
    .addr_i       (req_addr[1:0]),
    .misaligned_o (misaligned)
  );
`else
  assign misaligned = 1'b0;
`endif

  assign reject  = !func3_legal(req_write, req_func3) || misaligned;
  assign cnt_d   = cnt_q + 1'b1;
  assign timeout = (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    if (!rstN) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          req_q   <= '{write: req_write, func3: req_func3};
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          cnt_q   <= '0;
          err_q   <= reject;
          state_q <= reject ? RESP : ISSUE;
        end
        ISSUE: if (mem_ready) begin
          cnt_q   <= '0;
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          cnt_q <= cnt_d;
          if (timeout) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (!mem_ready) begin
            state_q <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          cnt_q <= cnt_d;
          // A completion seen on the last allowed cycle still wins over the timeout.
          if (mem_ready) begin
            rdata_q <= req_q.write ? '0 : mem_data_out;
            state_q <= RESP;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: if (resp_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command pulse is the ISSUE cycle in which the controller is ready; leaving
  // ISSUE on that same edge guarantees a single-cycle pulse.
  assign mem_read_En  = (state_q == ISSUE) && mem_ready && !req_q.write;
  assign mem_write_En = (state_q == ISSUE) && mem_ready &&  req_q.write;

  assign mem_func3   = req_q.func3;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
